// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types and encodings for the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_step
// Description : One shift-add multiply or restoring shift-subtract divide step.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opnd,
    output logic [2*WIDTH-1:0]   o_acc_next
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        w_trial = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_diff  = w_trial - {1'b0, i_opnd};
        if (!i_is_div) begin
            o_acc_next = {w_sum, i_acc[WIDTH-1:1]};
        end else if (w_diff[WIDTH]) begin
            o_acc_next = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
        end else begin
            o_acc_next = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
        end
    end

endmodule : mdu_step
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(WIDTH - 1);

    mdu_state_e         r_state, w_next_state;
    mdu_op_e            w_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc, w_acc_next, w_prod;
    logic [WIDTH-1:0]   r_opnd, r_hi, r_lo;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quo, w_rem, w_fix_hi, w_fix_lo;
    logic               r_sa, r_sb, r_div, r_dz, r_done;
    logic               w_signed, w_div;

    always_comb begin
        w_op     = mdu_op_e'(op);
        w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
        w_div    = (w_op == OP_DIV)  || (w_op == OP_DIVU);
        w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
        w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div   (r_div),
        .i_acc      (r_acc),
        .i_opnd     (r_opnd),
        .o_acc_next (w_acc_next)
    );

    // Sign flags are only ever set for signed ops, so unsigned results pass through.
    // A zero divisor leaves |a| as the remainder, so hi = a falls out of the sign fix.
    always_comb begin
        w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
        w_quo  = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem  = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        if (r_div) begin
            w_fix_hi = w_rem;
            w_fix_lo = r_dz ? '1 : w_quo;
        end else begin
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (r_cnt == c_last_step) w_next_state = FIX;
            FIX:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_opnd <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_div  <= 1'b0;
            r_dz   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (hi_we) r_hi <= wd;
                    if (lo_we) r_lo <= wd;
                    if (start) begin
                        r_cnt  <= '0;
                        r_sa   <= w_signed & a[WIDTH-1];
                        r_sb   <= w_signed & b[WIDTH-1];
                        r_div  <= w_div;
                        r_dz   <= w_div && (b == '0);
                        r_acc  <= {{WIDTH{1'b0}}, (w_div ? w_a_mag : w_b_mag)};
                        r_opnd <= w_div ? w_b_mag : w_a_mag;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule : mult_div_unit
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit with a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b, wd;
    logic             hi_we, lo_we;
    logic             busy, done;
    logic [WIDTH-1:0] hi, lo;

    int               checks   = 0;
    int               failures = 0;
    logic [63:0]      sb[$];

    mult_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation, push its expected {hi,lo}, then follow it to done.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                         input bit disturb, input bit mthi);
        int k;
        int nb;
        logic [63:0] exp;
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        if (mthi) begin hi_we = 1'b1; wd = 32'h0000_AAAA; end
        sb.push_back({ehi, elo});
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        if (mthi) chk({tag, "_mthi_with_start"}, {32'h0, hi}, {32'h0, 32'h0000_AAAA});
        k = 1; nb = 0;
        while (k <= 60) begin
            if (done) break;
            if (busy) nb++;
            if (disturb && k == 5) begin
                start = 1'b1; op = 2'b10; a = 32'h9; b = 32'h9;
                hi_we = 1'b1; lo_we = 1'b1; wd = 32'h1234;
            end else if (disturb && k == 6) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            k++;
            @(negedge clk);
        end
        chk({tag, "_done_edge"}, 64'(k), 64'd34);
        chk({tag, "_busy_cycles"}, 64'(nb), 64'd33);
        chk({tag, "_busy_at_done"}, {63'h0, busy}, 64'h0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_hilo"}, {hi, lo}, exp);
        end
        @(negedge clk);
        chk({tag, "_done_width"}, {63'h0, done}, 64'h0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wd = '0;
        #3;
        chk("reset_state", {60'h0, busy, done, 2'b00}, 64'h0);
        chk("reset_hilo", {hi, lo}, 64'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
        do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
        do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
        do_op("divu", 2'b11, 32'd100, 32'd7, 32'h2, 32'hE, 0, 0);
        do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 0);
        do_op("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0, 0);
        do_op("div_zero", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 0);

        // MTHI / MTLO while idle
        @(negedge clk);
        hi_we = 1'b1; wd = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_idle", {hi, lo}, {32'hDEAD_BEEF, 32'hFFFF_FFFF});
        lo_we = 1'b1; wd = 32'h0BAD_F00D;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_idle", {hi, lo}, {32'hDEAD_BEEF, 32'h0BAD_F00D});

        do_op("multu_disturb", 2'b01, 32'd2, 32'd3, 32'h0, 32'd6, 1, 0);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort_busy", {63'h0, busy}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ctrl", {62'h0, busy, done}, 64'h0);
        chk("abort_hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_abort_idle", {62'h0, busy, done}, 64'h0);

        do_op("multu_after_rst", 2'b01, 32'd4, 32'd5, 32'h0, 32'd20, 0, 1);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mult_div_unit
`default_nettype wire
